// File: rtl/cpu_ws_pkg.sv
// rtl/cpu_ws_pkg.sv - shared opcodes, ALU sub-ops, FSM states and instruction fields for cpu_ws
package cpu_ws_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_AND    = 4'd2;
  localparam logic [3:0] OP_OR     = 4'd3;
  localparam logic [3:0] OP_XOR    = 4'd4;
  localparam logic [3:0] OP_SHL    = 4'd5;
  localparam logic [3:0] OP_SHR    = 4'd6;
  localparam logic [3:0] OP_NOT    = 4'd7;
  localparam logic [3:0] OP_LOADLO = 4'd8;
  localparam logic [3:0] OP_LOADHI = 4'd9;
  localparam logic [3:0] OP_IN     = 4'd10;
  localparam logic [3:0] OP_OUT    = 4'd11;
  localparam logic [3:0] OP_JMP    = 4'd12;
  localparam logic [3:0] OP_BR     = 4'd13;
  localparam logic [3:0] OP_HALT   = 4'd14;
  localparam logic [3:0] OP_NOP    = 4'd15;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SHL = 3'd5;
  localparam logic [2:0] ALU_SHR = 3'd6;
  localparam logic [2:0] ALU_NOT = 3'd7;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_NEXT   = 3'd5,
    ST_HALT   = 3'd6,
    ST_FAULT  = 3'd7
  } state_e;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int R1_HI  = 11;
  localparam int R1_LO  = 8;
  localparam int R2_HI  = 7;
  localparam int R2_LO  = 4;
  localparam int R3_HI  = 3;
  localparam int R3_LO  = 0;
  localparam int BIG_HI = 7;
  localparam int BIG_LO = 0;

  function automatic logic op_writes(input logic [3:0] op);
    return (op <= OP_LOADHI) || (op == OP_IN);
  endfunction

endpackage

// File: rtl/cpu_ws_regfile.sv
// rtl/cpu_ws_regfile.sv - register stack with two read ports and one write port
// Indices at or above REG_COUNT read as zero and swallow writes.
module cpu_ws_regfile #(
  parameter int DATA_W    = 16,
  parameter int REG_COUNT = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        ra_a_i,
  input  logic [3:0]        ra_b_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o,
  input  logic              we_i,
  input  logic [3:0]        wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] regs_q [REG_COUNT];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        if (wa_i == 4'(i)) regs_q[i] <= wd_i;
      end
    end
  end

  always_comb begin
    rd_a_o = '0;
    rd_b_o = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (ra_a_i == 4'(i)) rd_a_o = regs_q[i];
      if (ra_b_i == 4'(i)) rd_b_o = regs_q[i];
    end
  end

endmodule

// File: rtl/cpu_ws.sv
// rtl/cpu_ws.sv - multi-cycle 16-bit-instruction CPU with wait-state fetch/port handshakes
// Adds HALT and a bounded wait timeout that parks the core in a sticky FAULT state.
module cpu_ws import cpu_ws_pkg::*; #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int REG_COUNT = 16,
  parameter int WAIT_MAX  = 255
) (
  input  logic              clk,
  input  logic              do_reset,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic [15:0]       imem_data,
  input  logic              imem_ack,
  output logic [ADDR_W-1:0] portaddr,
  output logic [DATA_W-1:0] portval,
  output logic              portget,
  output logic              portset,
  input  logic [DATA_W-1:0] portout,
  input  logic              portready,
  output logic              halted,
  output logic              fault,
  output logic [2:0]        state,
  output logic [3:0]        opcode
);

  localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  state_e            state_q, state_d;
  logic [15:0]       ir_q;
  logic [ADDR_W-1:0] ip_q, ip_next, br_off;
  logic [DATA_W-1:0] a_q, b_q, res_q, alu_res, rd_a, rd_b;
  logic [CW-1:0]     wait_q, wait_d;
  logic              fault_q, started_q, waiting, timeout;
  logic [3:0]        op, r1, r2, r3;
  logic [7:0]        big;

  assign op  = ir_q[OP_HI:OP_LO];
  assign r1  = ir_q[R1_HI:R1_LO];
  assign r2  = ir_q[R2_HI:R2_LO];
  assign r3  = ir_q[R3_HI:R3_LO];
  assign big = ir_q[BIG_HI:BIG_LO];

  // ALU ops read r2/r3; everything else reads r1 (data/branch test) and r2 (port base).
  cpu_ws_regfile #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT)) u_regfile (
    .clk_i  (clk),
    .rst_i  (do_reset),
    .ra_a_i (op[3] ? r1 : r2),
    .ra_b_i (op[3] ? r2 : r3),
    .rd_a_o (rd_a),
    .rd_b_o (rd_b),
    .we_i   (state_q == ST_WB),
    .wa_i   (r1),
    .wd_i   (res_q)
  );

  // started_q holds off the first fetch until one clock after reset release.
  assign waiting = ((state_q == ST_FETCH) && started_q) || (state_q == ST_MEM);
  assign timeout = (WAIT_MAX != 0) && (wait_q == CW'(WAIT_MAX));
  assign wait_d  = (waiting && (state_d == state_q)) ? wait_q + CW'(1) : '0;

  always_ff @(posedge clk or posedge do_reset) begin
    if (do_reset) state_q <= ST_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (started_q) begin
                   if (imem_ack)     state_d = ST_DECODE;
                   else if (timeout) state_d = ST_FAULT;
                 end
      ST_DECODE: if (op == OP_HALT)                     state_d = ST_HALT;
                 else if (op == OP_IN || op == OP_OUT)  state_d = ST_MEM;
                 else                                   state_d = ST_EXEC;
      ST_EXEC:   state_d = op_writes(op) ? ST_WB : ST_NEXT;
      ST_MEM:    if (portready)    state_d = (op == OP_IN) ? ST_WB : ST_NEXT;
                 else if (timeout) state_d = ST_FAULT;
      ST_WB:     state_d = ST_NEXT;
      ST_NEXT:   state_d = ST_FETCH;
      default:   state_d = state_q;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    portget  = 1'b0;
    portset  = 1'b0;
    case (state_q)
      ST_FETCH: imem_req = started_q;
      ST_MEM: begin
        portget = (op == OP_IN);
        portset = (op == OP_OUT);
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_res = a_q;
    if (!op[3]) begin
      case (op[2:0])
        ALU_ADD: alu_res = a_q + b_q;
        ALU_SUB: alu_res = a_q - b_q;
        ALU_AND: alu_res = a_q & b_q;
        ALU_OR:  alu_res = a_q | b_q;
        ALU_XOR: alu_res = a_q ^ b_q;
        ALU_SHL: alu_res = a_q << b_q[3:0];
        ALU_SHR: alu_res = a_q >> b_q[3:0];
        ALU_NOT: alu_res = ~a_q;
        default: alu_res = a_q;
      endcase
    end else if (op == OP_LOADLO) begin
      alu_res[7:0] = big;
    end else if (op == OP_LOADHI) begin
      alu_res[15:8] = big;
    end
  end

  assign br_off = {{(ADDR_W-8){big[7]}}, big};

  always_comb begin
    ip_next = ip_q + ADDR_W'(1);
    if (op == OP_JMP || (op == OP_BR && a_q != '0)) ip_next = ip_q + br_off;
  end

  always_ff @(posedge clk or posedge do_reset) begin
    if (do_reset) begin
      started_q <= 1'b0;
      ir_q      <= '0;
      ip_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      wait_q    <= '0;
      fault_q   <= 1'b0;
    end else begin
      started_q <= 1'b1;
      wait_q    <= wait_d;
      if (state_d == ST_FAULT) fault_q <= 1'b1;
      case (state_q)
        ST_FETCH:  if (started_q && imem_ack) ir_q <= imem_data;
        ST_DECODE: begin
          a_q <= rd_a;
          b_q <= rd_b;
        end
        ST_EXEC:   res_q <= alu_res;
        ST_MEM:    if (portready && op == OP_IN) res_q <= portout;
        ST_NEXT:   ip_q <= ip_next;
        default: ;
      endcase
    end
  end

  assign imem_addr = ip_q;
  assign portaddr  = ADDR_W'(b_q) + ADDR_W'(r3);
  assign portval   = a_q;
  assign halted    = (state_q == ST_HALT) || (state_q == ST_FAULT);
  assign fault     = fault_q;
  assign state     = state_q;
  assign opcode    = op;

endmodule

// File: doc/cpu_ws.md
Name: cpu_ws

Overview:
- Parametrised successor to the multi-cycle 16-bit CPU top.
- Integrates the register stack, the control FSM and the instruction pointer, with request/acknowledge handshakes on both instruction fetch and port I/O, so slow memories and peripherals can insert wait states.
- Adds a HALT instruction and a bounded port-wait timeout that raises a sticky fault.
- Sits at the system top, between the instruction ROM and the port bus.

Parameters:
- DATA_W, 16: register/ALU/port data width; must be >= 16; instruction word stays 16 bits.
- ADDR_W, 16: instruction pointer and port address width.
- REG_COUNT, 16: number of registers; <= 16; register indices >= REG_COUNT read 0, writes to them are dropped.
- WAIT_MAX, 255: maximum cycles to wait for imem_ack/portready before faulting; 0 disables the timeout.

Ports:
- clk  in  1  clock; everything on rising edge.
- do_reset  in  1  reset, asynchronous, active-high.
- imem_addr  out  ADDR_W  fetch address, equals the instruction pointer.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_data  in  16  instruction word; sampled in the cycle imem_ack=1.
- imem_ack  in  1  fetch acknowledge.
- portaddr  out  ADDR_W  port address = reg[r2] + zero-extended smallval, truncated to ADDR_W.
- portval  out  DATA_W  store data = reg[r1].
- portget  out  1  read strobe; held during MEM for IN.
- portset  out  1  write strobe; held during MEM for OUT.
- portout  in  DATA_W  read data; sampled in the cycle portready=1.
- portready  in  1  port acknowledge.
- halted  out  1  core is in HALT or FAULT.
- fault  out  1  sticky timeout flag.
- state  out  3  FSM state encoding.
- opcode  out  4  opcode of the latched instruction.

Behaviour:
- Instruction fields: opcode=[15:12], r1=[11:8], r2=[7:4], r3=smallval=[3:0], bigval=[7:0].
- Opcodes 0-7 are ALU ops ADD, SUB, AND, OR, XOR, SHL, SHR, NOT: r1 <= r2 op r3. NOT ignores r3. Shifts use reg[r3][3:0] as the shift amount. Results wrap mod 2^DATA_W.
- 8 LOADLO: r1[7:0] <= bigval.
- 9 LOADHI: r1[15:8] <= bigval.
- LOADLO/LOADHI preserve all other bits of r1.
- 10 IN: r1 <= portout.
- 11 OUT: reads r1 and r2; no register write.
- 12 JMP: ip += sign-extended bigval.
- 13 BR: if reg[r1] != 0 then ip += sext(bigval), else ip += 1.
- 14 HALT; 15 NOP.
- FSM states: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, NEXT=5, HALT=6, FAULT=7.
  - FETCH: imem_req=1. On imem_ack, latch the instruction and go to DECODE.
  - DECODE: read operands (1 cycle). Go to HALT for HALT, MEM for IN/OUT, otherwise EXEC.
  - EXEC: compute ALU result / load value (1 cycle). Go to WB.
  - MEM: assert the strobe. On portready, go to WB (IN) or NEXT (OUT). The strobe drops in the cycle after portready.
  - WB: write r1 if the opcode writes. Go to NEXT.
  - NEXT: update ip, then go to FETCH.
- Minimum latency: ALU op = 5 cycles (FETCH+DECODE+EXEC+WB+NEXT) with same-cycle ack. JMP/BR/NOP/OUT skip WB.
- Wait counter:
  - Clears on every state entry.
  - Increments each cycle spent in FETCH or MEM without acknowledge.
  - When it reaches WAIT_MAX: drop all strobes, set fault=1, enter FAULT.
  - An acknowledge arriving in the same cycle as the counter reaching WAIT_MAX wins; no fault.
- HALT and FAULT are terminal; only do_reset leaves them. halted=1 in both.
- ip wraps mod 2^ADDR_W, both forward and backward.
- Reset, asynchronous at any point including mid-handshake:
  - state=FETCH; ip=0; all registers=0; fault=0; strobes and imem_req drop immediately.
  - imem_req rises on the first clock edge after deassertion.
- imem_ack and portready are ignored in states that do not wait for them.

Decomposition:
- Shared package holds the OP_* opcode constants, ALU sub-op codes, ST_* state encodings, and the instruction field positions.
- Natural sub-module: cpu_ws_regfile, parametrised in DATA_W and REG_COUNT, with two read ports and one write port.
- The ALU stays inline, or reuses the existing alu widened to DATA_W.

Test Plan:
- LOADLO r1,0x34; LOADHI r1,0x12; ADD r3,r1,r1 with immediate acks -> reg3 = 0x2468; each ALU instruction completes in 5 cycles; ip = 3.
- OUT with r1=0xBEEF, r2=0x10, smallval 3, portready delayed 4 cycles -> portset held exactly 4 cycles plus the ack cycle, portaddr = 0x13, portval = 0xBEEF, then NEXT.
- BR with r1=0 and bigval=0xFE -> ip += 1. BR with r1=5 at ip=2, bigval=0xFE -> ip = 0. JMP at ip=0 with bigval=0xFF -> ip = 0xFFFF (wrap).
- IN with portready never asserted, WAIT_MAX=8 -> FAULT after 8 cycles, fault=1, halted=1, portget=0. A variant acking exactly at count 8 completes with no fault.
- HALT -> state 6; imem_req stays 0 for 20 cycles; do_reset mid-cycle drops outputs asynchronously and fetch restarts at ip 0.
- Reset asserted while MEM is waiting -> portget falls without a clock edge; no register write; fault stays 0.
